// File: rtl/lsu_pkg.sv
// Shared definitions for the dmem load/store unit: funct3 codes, FSM encoding
// and the byte-lane shift helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWrite,
        StResp
    } state_e;

    // Bit offset of the addressed lane; halfwords select their lane with addr[1] only.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [2:0] f3);
        if (f3[1:0] == 2'b01) begin
            return {off[1], 4'b0000};
        end
        return {off, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] lane;

    always_comb begin
        shamt   = lane_shift(off_i, f3_i);
        lane    = rd_i >> shamt;
        load_o  = rd_i;
        merge_o = wdata_i;
        case (f3_i[1:0])
            2'b00: begin
                load_o  = {{24{lane[7] & ~f3_i[2]}}, lane[7:0]};
                merge_o = (rd_i & ~(32'h0000_00FF << shamt))
                        | ({24'b0, wdata_i[7:0]} << shamt);
            end
            2'b01: begin
                load_o  = {{16{lane[15] & ~f3_i[2]}}, lane[15:0]};
                merge_o = (rd_i & ~(32'h0000_FFFF << shamt))
                        | ({16'b0, wdata_i[15:0]} << shamt);
            end
            default: begin
                load_o  = rd_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a word-only data memory;
// sub-word stores become read-modify-write, bad accesses are faulted.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       wd_q, wd_d;

    logic              req_fault;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    lsu_align u_align (
        .rd_i    (mem_rd),
        .wdata_i (wdata_q),
        .off_i   (addr_q[1:0]),
        .f3_i    (f3_q),
        .load_o  (load_data),
        .merge_o (merge_data)
    );

    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_fault = 1'b0;
            F3_BU, F3_HU:     req_fault = req_we;
            default:          req_fault = 1'b1;
        endcase
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_fault = 1'b1;
        end
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00) begin
            req_fault = 1'b1;
        end
    end

    // Write strobe is pure state decode so an async reset removes it at once.
    always_comb begin
        mem_we = (state_q == StWrite) || (state_q == StAccess && we_q && f3_q == F3_W);
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        if (state_q == StWrite) begin
            mem_wd = merge_q;
        end else if (mem_we) begin
            mem_wd = wdata_q;
        end else begin
            mem_wd = wd_q;
        end
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_fault = (state_q == StResp) && fault_q;
        rsp_rdata = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        wd_d    = mem_we ? mem_wd : wd_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    if (req_fault) begin
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (!we_q) begin
                    rdata_d = load_data;
                    state_d = StResp;
                end else if (f3_q == F3_W) begin
                    state_d = StResp;
                end else begin
                    merge_d = merge_data;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            wd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word-only memory model.
module tb_dmem_lsu;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    int          rsp_cyc, we_cnt, we_cyc, cnt;
    logic        fault, ready1;
    logic [31:0] rdata;

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and watches six cycles after the accept edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_cyc = -1;
        we_cnt  = 0;
        we_cyc  = -1;
        fault   = 1'bx;
        rdata   = 32'hx;
        ready1  = 1'bx;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) ready1 = req_ready;
            if (mem_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c;
                fault   = rsp_fault;
                rdata   = rsp_rdata;
            end
        end
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp);
        run_req(1'b0, f3, addr, 32'h0);
        check({tag, "_rsp_cyc"}, rsp_cyc, 32'd2);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_fault"}, {31'b0, fault}, 32'd0);
        check({tag, "_we_cnt"}, we_cnt, 32'd0);
    endtask

    task automatic check_fault(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr);
        run_req(we, f3, addr, 32'hDEAD_BEEF);
        check({tag, "_rsp_cyc"}, rsp_cyc, 32'd1);
        check({tag, "_fault"}, {31'b0, fault}, 32'd1);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_we_cnt"}, we_cnt, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // SW initialises word 4
        run_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB);
        check("sw_rsp_cyc", rsp_cyc, 32'd2);
        check("sw_we_cnt", we_cnt, 32'd1);
        check("sw_we_cyc", we_cyc, 32'd1);
        check("sw_fault", {31'b0, fault}, 32'd0);
        check("sw_mem4", mem[4], 32'h8899_AABB);

        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_ready1", {31'b0, ready1}, 32'd0);
        check("lw_rsp_cyc", rsp_cyc, 32'd2);
        check("lw_rdata", rdata, 32'h8899_AABB);
        check("lw_fault", {31'b0, fault}, 32'd0);
        check("lw_mem_a_hold", mem_a, 32'h10);

        check_load("lb", 3'b000, 32'h13, 32'hFFFF_FF88);
        check_load("lbu", 3'b100, 32'h13, 32'h0000_0088);
        check_load("lb_pos", 3'b000, 32'h10, 32'hFFFF_FFBB);
        check_load("lh", 3'b001, 32'h12, 32'hFFFF_8899);
        check_load("lhu", 3'b101, 32'h10, 32'h0000_AABB);

        run_req(1'b1, 3'b000, 32'h11, 32'h1234_5677);
        check("sb_rsp_cyc", rsp_cyc, 32'd3);
        check("sb_we_cnt", we_cnt, 32'd1);
        check("sb_we_cyc", we_cyc, 32'd2);
        check("sb_mem4", mem[4], 32'h8899_77BB);
        check("sb_rdata_kept", rdata, 32'h0000_AABB);

        run_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB);
        check("sw2_mem4", mem[4], 32'h8899_AABB);

        run_req(1'b1, 3'b001, 32'h12, 32'h0000_CAFE);
        check("sh_rsp_cyc", rsp_cyc, 32'd3);
        check("sh_we_cnt", we_cnt, 32'd1);
        check("sh_mem4", mem[4], 32'hCAFE_AABB);
        check("sh_mem_wd_hold", mem_wd, 32'hCAFE_AABB);

        check_fault("f_lw_mis", 1'b0, 3'b010, 32'h11);
        check_fault("f_sh_mis", 1'b1, 3'b001, 32'h13);
        check_fault("f_f3_011", 1'b0, 3'b011, 32'h10);
        check_fault("f_st_bu", 1'b1, 3'b100, 32'h10);
        check("f_mem4", mem[4], 32'hCAFE_AABB);

        // Reset while an SB sits in ACCESS
        check_load("lw_pre", 3'b010, 32'h10, 32'hCAFE_AABB);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("ra_mem_we", {31'b0, mem_we}, 32'd0);
        check("ra_ready", {31'b0, req_ready}, 32'd1);
        check("ra_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("ra_no_rsp", cnt, 32'd0);
        check("ra_mem4", mem[4], 32'hCAFE_AABB);

        // Reset while an SH drives its write
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h1111;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rw_mem_we_before", {31'b0, mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rw_mem_we_after", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("rw_no_rsp", cnt, 32'd0);
        check("rw_mem4", mem[4], 32'hCAFE_AABB);

        check_load("lw_post", 3'b010, 32'h10, 32'hCAFE_AABB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the riscvsingle core's memory-stage request and the word-only data memory `dmem`. Sub-word loads are formatted with sign or zero extension. Sub-word stores are turned into a read-modify-write, because `dmem` writes only whole words. Misaligned and unsupported accesses are rejected with a fault flag and never reach memory. The core stalls on `req_ready`/`rsp_valid`.

## Interface
- `ADDR_W`, 32, byte address width (data fixed at 32 bits)
- `clk` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: core request present
- `req_ready` out 1: unit idle, request accepted this edge if `req_valid`
- `req_we` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RV32I width/sign code (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- `req_addr` in ADDR_W: byte address
- `req_wdata` in 32: store data (rs2)
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_rdata` out 32: formatted load data
- `rsp_fault` out 1: access rejected; valid with `rsp_valid`
- `mem_we` out 1: to `dmem` `we`
- `mem_a` out ADDR_W: to `dmem` `a`, always word aligned
- `mem_wd` out 32: to `dmem` `wd`
- `mem_rd` in 32: from `dmem` `rd`, combinational read of `mem_a`

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch we/funct3/addr/wdata.
  - Fault check: unsupported funct3 (011, 110, 111, or store with funct3[2]=1), halfword with addr[0]=1, or word with addr[1:0]≠0. A faulting request goes to RESP with fault=1. Otherwise it goes to ACCESS.
- **ACCESS**: `mem_a`={addr_q[31:2],2'b00}.
  - Load: `rsp_rdata` ← extracted lane of `mem_rd`, then RESP.
  - SW: `mem_we`=1, `mem_wd`=wdata_q, then RESP.
  - SB/SH: merge register ← `mem_rd` with the addressed lane(s) replaced by wdata_q[7:0] or wdata_q[15:0], then WRITE.
- **WRITE**: `mem_we`=1, `mem_wd`=merge register, same `mem_a`, then RESP.
- **RESP**: `rsp_valid`=1 and `rsp_fault`=fault_q for one cycle, then IDLE. The next request can be accepted only in the following IDLE cycle.
- **Byte lanes**: little-endian. Byte k = bits [8k+7:8k], k=addr[1:0]. Halfword lane = addr[1]. LB/LH sign-extend. LBU/LHU zero-extend.
- **`rsp_rdata`**: updated only by successful loads. Stores leave it unchanged. Faults force it to 0.
- `mem_we` is decoded combinationally from state, so an asynchronous reset drops it immediately.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1
  - `rsp_valid`=0, `rsp_fault`=0, `rsp_rdata`=0
  - `mem_we`=0, `mem_a`=0, `mem_wd`=0
  - all latches 0
- Accept edge = cycle 0.
- Load, SW: `rsp_valid` high in cycle 2.
- SB/SH: memory written at the end of cycle 2; `rsp_valid` high in cycle 3.
- Fault: `rsp_valid` high in cycle 1; `mem_we` never asserted.
- `req_ready` is low from cycle 1 until `rsp_valid` has been high for a cycle. `req_valid` is ignored outside IDLE.
- `mem_wd` holds its last value when `mem_we`=0. `mem_a` holds the latched word address between requests.
- Reset during ACCESS or WRITE: the word is not written (SB/SH) or written only if the clock edge precedes reset. No `rsp_valid` is issued for the aborted request.
- Back-to-back requests are separated by the RESP cycle. Throughput is one load per 3 cycles.

## Structure
- `lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, lane-index helper.
- Sub-module `lsu_align` (combinational):
  - load path: `mem_rd` + addr[1:0] + funct3 → extended data
  - store path: old word + wdata + addr[1:0] + funct3 → merged word
- Top holds the FSM and registers.

## Test plan
- Reset, then LW addr 0x10 with `dmem` word 4 = 0x8899AABB → `rsp_valid` in cycle 2, `rsp_rdata`=0x8899AABB, `rsp_fault`=0.
- LB addr 0x13 on that word → 0xFFFFFF88. LBU addr 0x13 → 0x00000088. LH addr 0x12 → 0xFFFF8899. LHU addr 0x10 → 0x0000AABB.
- SB addr 0x11, wdata 0x12345677 → `mem_we` once in cycle 2, word 4 = 0x8899 77 BB (0x889977BB), `rsp_valid` in cycle 3.
- SH addr 0x12, wdata 0xCAFE → word 4 = 0xCAFEAABB.
- LW addr 0x11, SH addr 0x13, funct3=011 → `rsp_fault`=1 in cycle 1, `rsp_rdata`=0, `mem_we` stays 0, memory unchanged.
- Assert `reset_n`=0 during ACCESS of an SB → `mem_we` drops immediately, `req_ready`=1, no `rsp_valid`, word unchanged. The next LW succeeds.
